rom_word_arbiter: RTL and testbench

Shares one pair of 8 KB program ROM halves (hi byte and lo byte, each a 13-bit-address synchronous ROM with a registered read of 1 cycle) between two requesters. Port 0 is the CPU fetch path and has priority. Port 1 is the auxiliary path (self-test checksum scanner / debug reader). The block sequences each ROM access, assembles the 16-bit word, returns it with a one-cycle ack pulse, and limits port 1 starvation with a counter.

---
 rtl/rom_arb_pkg.sv | 17 +
 rtl/rom_arb_pick.sv | 24 ++
 rtl/rom_word_arbiter.sv | 123 ++++++++++++
 tb/tb_rom_word_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the dual-port program ROM word arbiter.
package rom_arb_pkg;

    localparam int AW_DEFAULT = 13;
    localparam int STARVE_W   = 4;

    localparam logic P_CPU = 1'b0;
    localparam logic P_AUX = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner selection: CPU port has priority unless the aux port
// has been passed over STARVE_MAX times in a row.
module rom_arb_pick
    import rom_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
)
(
    input  logic                req0,
    input  logic                req1,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                win_valid,
    output logic                win_port
);

    always_comb begin
        win_valid = req0 | req1;
        win_port  = P_CPU;
        if (req1 && (!req0 || starve_cnt == STARVE_W'(STARVE_MAX))) begin
            win_port = P_AUX;
        end
    end

endmodule

// File: rtl/rom_word_arbiter.sv
// Shares the hi/lo program ROM halves between the CPU fetch port and the
// aux port, assembling one 16-bit word per 4-cycle access.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | no access; arbitrate and register the winner's address
//  S_ISSUE | ROM enabled, ROM samples rom_a at the end of this cycle
//  S_WAIT  | ROM data valid, captured into the granted port's data reg
//  S_DONE  | granted port's ack pulse; requests are not sampled
module rom_word_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW         = AW_DEFAULT,
    parameter int STARVE_MAX = 4
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_ack,
    output logic [15:0]   p0_data,
    input  logic          p1_req,
    input  logic [AW-1:0] p1_addr,
    output logic          p1_ack,
    output logic [15:0]   p1_data,
    output logic [AW-1:0] rom_a,
    output logic          rom_ce,
    output logic          rom_oe,
    input  logic [7:0]    rom_d_hi,
    input  logic [7:0]    rom_d_lo,
    output logic          busy
);

    state_t              state_q, state_d;
    logic [AW-1:0]       rom_a_q, rom_a_d;
    logic                grant_q, grant_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [15:0]         p0_data_q, p0_data_d;
    logic [15:0]         p1_data_q, p1_data_d;
    logic                win_valid;
    logic                win_port;

    rom_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .req0       (p0_req),
        .req1       (p1_req),
        .starve_cnt (starve_q),
        .win_valid  (win_valid),
        .win_port   (win_port)
    );

    always_comb begin
        state_d   = state_q;
        rom_a_d   = rom_a_q;
        grant_d   = grant_q;
        starve_d  = starve_q;
        p0_data_d = p0_data_q;
        p1_data_d = p1_data_q;

        case (state_q)
            S_IDLE: begin
                if (!p1_req) begin
                    starve_d = '0;
                end
                if (win_valid) begin
                    state_d = S_ISSUE;
                    grant_d = win_port;
                    if (win_port == P_AUX) begin
                        rom_a_d  = p1_addr;
                        starve_d = '0;
                    end else begin
                        rom_a_d = p0_addr;
                        // Count only CPU grants that actually kept aux waiting.
                        if (p1_req && starve_q < STARVE_W'(STARVE_MAX)) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_DONE;
                if (grant_q == P_AUX) begin
                    p1_data_d = {rom_d_hi, rom_d_lo};
                end else begin
                    p0_data_d = {rom_d_hi, rom_d_lo};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rom_a_q   <= '0;
            grant_q   <= P_CPU;
            starve_q  <= '0;
            p0_data_q <= '0;
            p1_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rom_a_q   <= rom_a_d;
            grant_q   <= grant_d;
            starve_q  <= starve_d;
            p0_data_q <= p0_data_d;
            p1_data_q <= p1_data_d;
        end
    end

    assign p0_ack  = (state_q == S_DONE) && (grant_q == P_CPU);
    assign p1_ack  = (state_q == S_DONE) && (grant_q == P_AUX);
    assign p0_data = p0_data_q;
    assign p1_data = p1_data_q;
    assign rom_a   = rom_a_q;
    assign rom_ce  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign rom_oe  = rom_ce;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_word_arbiter.sv
// Bench for rom_word_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of arbitration, latency and ROM contents.
module tb_rom_word_arbiter;

    localparam int AW         = 13;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p1_req;
    logic [AW-1:0] p0_addr, p1_addr;
    logic          p0_ack, p1_ack;
    logic [15:0]   p0_data, p1_data;
    logic [AW-1:0] rom_a;
    logic          rom_ce, rom_oe, busy;
    logic [7:0]    rom_d_hi, rom_d_lo;

    logic [7:0] hi_mem [8192];
    logic [7:0] lo_mem [8192];

    int vectors;
    int miscompares;

    rom_word_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk      (clk),
        .reset    (reset),
        .p0_req   (p0_req),
        .p0_addr  (p0_addr),
        .p0_ack   (p0_ack),
        .p0_data  (p0_data),
        .p1_req   (p1_req),
        .p1_addr  (p1_addr),
        .p1_ack   (p1_ack),
        .p1_data  (p1_data),
        .rom_a    (rom_a),
        .rom_ce   (rom_ce),
        .rom_oe   (rom_oe),
        .rom_d_hi (rom_d_hi),
        .rom_d_lo (rom_d_lo),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Synchronous ROM halves; garbage on the bus when not enabled.
    always @(posedge clk) begin
        if (rom_ce && rom_oe) begin
            rom_d_hi <= hi_mem[rom_a];
            rom_d_lo <= lo_mem[rom_a];
        end else begin
            rom_d_hi <= 8'($urandom);
            rom_d_lo <= 8'($urandom);
        end
    end

    function automatic logic [15:0] word_at(input logic [AW-1:0] a);
        return {hi_mem[a], lo_mem[a]};
    endfunction

    task automatic test_reset();
        reset   = 1'b1;
        p0_req  = 1'b1;
        p1_req  = 1'b1;
        p0_addr = 13'h0123;
        p1_addr = 13'h0456;
        repeat (3) @(negedge clk);
        vectors++;
        if ({p0_ack, p1_ack, rom_ce, rom_oe, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 00000", {p0_ack, p1_ack, rom_ce, rom_oe, busy});
        end
        vectors++;
        if ({rom_a, p0_data, p1_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: rom_a=%h p0_data=%h p1_data=%h expected all 0", rom_a, p0_data, p1_data);
        end
        reset  = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        p0_req  = 1'b1;
        p0_addr = 13'h0000;
        @(negedge clk);
        vectors++;
        if ({busy, rom_ce, rom_oe, p0_ack} !== 4'b1110 || rom_a !== 13'h0000) begin
            miscompares++;
            $display("FAIL single_issue: busy/ce/oe/ack=%b rom_a=%h expected 1110 0000", {busy, rom_ce, rom_oe, p0_ack}, rom_a);
        end
        @(negedge clk);
        vectors++;
        if ({p0_ack, rom_ce} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_wait: ack/ce=%b expected 01", {p0_ack, rom_ce});
        end
        @(negedge clk);
        vectors++;
        if ({p0_ack, p1_ack, rom_ce, busy} !== 4'b1001 || p0_data !== 16'h4E71) begin
            miscompares++;
            $display("FAIL single_ack: ack0/ack1/ce/busy=%b data=%h expected 1001 4e71", {p0_ack, p1_ack, rom_ce, busy}, p0_data);
        end
        p0_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({p0_ack, busy} !== 2'b00 || p0_data !== 16'h4E71) begin
            miscompares++;
            $display("FAIL single_after: ack/busy=%b data=%h expected 00 4e71", {p0_ack, busy}, p0_data);
        end
    endtask

    task automatic test_both();
        p0_req  = 1'b1;
        p0_addr = 13'h0010;
        p1_req  = 1'b1;
        p1_addr = 13'h1FFF;
        repeat (3) @(negedge clk);
        vectors++;
        if ({p0_ack, p1_ack} !== 2'b10 || p0_data !== word_at(13'h0010)) begin
            miscompares++;
            $display("FAIL both_first: acks=%b data=%h expected 10 %h", {p0_ack, p1_ack}, p0_data, word_at(13'h0010));
        end
        p0_req = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({p0_ack, p1_ack} !== 2'b00) begin
            miscompares++;
            $display("FAIL both_early: acks=%b expected 00", {p0_ack, p1_ack});
        end
        @(negedge clk);
        vectors++;
        if ({p0_ack, p1_ack} !== 2'b01 || p1_data !== word_at(13'h1FFF)) begin
            miscompares++;
            $display("FAIL both_second: acks=%b data=%h expected 01 %h", {p0_ack, p1_ack}, p1_data, word_at(13'h1FFF));
        end
        p1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starve();
        logic [AW-1:0] a0, a1;
        int            cnt;
        logic          exp_p;
        a0      = 13'($urandom_range(8191));
        a1      = 13'($urandom_range(8191));
        p0_req  = 1'b1;
        p0_addr = a0;
        p1_req  = 1'b1;
        p1_addr = a1;
        cnt     = 0;
        for (int g = 0; g < 10; g++) begin
            exp_p = (cnt == STARVE_MAX);
            if (exp_p) cnt = 0;
            else if (cnt < STARVE_MAX) cnt = cnt + 1;
            repeat (3) @(negedge clk);
            vectors++;
            if ({p0_ack, p1_ack} !== (exp_p ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL starve_order grant %0d: acks=%b expected %b", g, {p0_ack, p1_ack}, exp_p ? 2'b01 : 2'b10);
            end
            vectors++;
            if ((exp_p ? p1_data : p0_data) !== (exp_p ? word_at(a1) : word_at(a0))) begin
                miscompares++;
                $display("FAIL starve_data grant %0d: got %h expected %h", g, exp_p ? p1_data : p0_data, exp_p ? word_at(a1) : word_at(a0));
            end
            if (g == 9) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        a       = 13'h0ABC;
        p1_req  = 1'b1;
        p1_addr = 13'h0777;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({p0_ack, p1_ack, rom_ce, rom_oe, busy} !== 5'b0 || {rom_a, p0_data, p1_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: ctrl=%b rom_a=%h d0=%h d1=%h expected all 0",
                     {p0_ack, p1_ack, rom_ce, rom_oe, busy}, rom_a, p0_data, p1_data);
        end
        reset   = 1'b0;
        p1_req  = 1'b0;
        @(negedge clk);
        p0_req  = 1'b1;
        p0_addr = a;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({p0_ack, p1_ack} !== ((k == 3) ? 2'b10 : 2'b00)) begin
                miscompares++;
                $display("FAIL reset_recover cycle %0d: acks=%b expected %b", k, {p0_ack, p1_ack}, (k == 3) ? 2'b10 : 2'b00);
            end
        end
        vectors++;
        if (p0_data !== word_at(a)) begin
            miscompares++;
            $display("FAIL reset_recover_data: got %h expected %h", p0_data, word_at(a));
        end
        p0_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic [AW-1:0] a;
        a       = 13'($urandom_range(8191));
        p0_req  = 1'b1;
        p0_addr = a;
        repeat (3) @(negedge clk);
        vectors++;
        if (p0_ack !== 1'b1 || p0_data !== word_at(a)) begin
            miscompares++;
            $display("FAIL hold_first: ack=%b data=%h expected 1 %h", p0_ack, p0_data, word_at(a));
        end
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            vectors++;
            if (p0_ack !== (k == 7) || busy !== (k != 4) || p0_data !== word_at(a)) begin
                miscompares++;
                $display("FAIL hold_cycle %0d: ack=%b busy=%b data=%h expected %b %b %h",
                         k, p0_ack, busy, p0_data, k == 7, k != 4, word_at(a));
            end
        end
        p0_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_data_hold();
        logic [AW-1:0] x, y;
        logic [15:0]   w1;
        x       = 13'($urandom_range(8191));
        y       = x ^ 13'h0001;
        w1      = word_at(x);
        p1_req  = 1'b1;
        p1_addr = x;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin
                p0_req  = 1'b1;
                p0_addr = y;
            end
            @(negedge clk);
            vectors++;
            if (busy !== (k % 4 != 0)) begin
                miscompares++;
                $display("FAIL dhold_busy cycle %0d: got %b expected %b", k, busy, k % 4 != 0);
            end
            if (k >= 3) begin
                vectors++;
                if (p1_data !== w1) begin
                    miscompares++;
                    $display("FAIL dhold_p1data cycle %0d: got %h expected %h", k, p1_data, w1);
                end
            end
            if (k == 3) p1_req = 1'b0;
            if (k == 7) begin
                vectors++;
                if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_data !== word_at(y)) begin
                    miscompares++;
                    $display("FAIL dhold_p0: ack0=%b ack1=%b data=%h expected 1 0 %h", p0_ack, p1_ack, p0_data, word_at(y));
                end
                p0_req = 1'b0;
            end
        end
    endtask

    // Model: a grant taken in cycle c is acked in c+3 and frees the block at c+4.
    task automatic test_random();
        int            ack_cyc, ack_port, starve;
        logic [AW-1:0] ack_addr;
        logic [15:0]   exp0, exp1;
        logic          e_ack0, e_ack1, e_busy, e_ce;
        reset  = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        ack_cyc  = -10;
        ack_port = 0;
        ack_addr = '0;
        starve   = 0;
        exp0     = '0;
        exp1     = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            e_ack0 = (cyc == ack_cyc) && (ack_port == 0);
            e_ack1 = (cyc == ack_cyc) && (ack_port == 1);
            if (e_ack0) exp0 = word_at(ack_addr);
            if (e_ack1) exp1 = word_at(ack_addr);
            e_busy = (cyc <= ack_cyc);
            e_ce   = (cyc == ack_cyc - 2) || (cyc == ack_cyc - 1);
            vectors++;
            if ({p0_ack, p1_ack, busy, rom_ce, rom_oe} !== {e_ack0, e_ack1, e_busy, e_ce, e_ce}) begin
                miscompares++;
                $display("FAIL rand_ctrl cyc %0d: ack0/ack1/busy/ce/oe=%b expected %b", cyc,
                         {p0_ack, p1_ack, busy, rom_ce, rom_oe}, {e_ack0, e_ack1, e_busy, e_ce, e_ce});
            end
            vectors++;
            if (p0_data !== exp0 || p1_data !== exp1) begin
                miscompares++;
                $display("FAIL rand_data cyc %0d: d0=%h d1=%h expected %h %h", cyc, p0_data, p1_data, exp0, exp1);
            end
            if (e_ce) begin
                vectors++;
                if (rom_a !== ack_addr) begin
                    miscompares++;
                    $display("FAIL rand_rom_a cyc %0d: got %h expected %h", cyc, rom_a, ack_addr);
                end
            end
            if (e_ack0) begin
                if ($urandom_range(3) != 0) p0_req = 1'b0;
            end else if (!p0_req && $urandom_range(1) == 0) begin
                p0_req  = 1'b1;
                p0_addr = 13'($urandom_range(8191));
            end
            if (e_ack1) begin
                if ($urandom_range(3) != 0) p1_req = 1'b0;
            end else if (!p1_req && $urandom_range(2) == 0) begin
                p1_req  = 1'b1;
                p1_addr = 13'($urandom_range(8191));
            end
            if (cyc > ack_cyc) begin
                if (!p1_req) starve = 0;
                if (p0_req || p1_req) begin
                    if (p1_req && (!p0_req || starve == STARVE_MAX)) begin
                        ack_port = 1;
                        ack_addr = p1_addr;
                        starve   = 0;
                    end else begin
                        ack_port = 0;
                        ack_addr = p0_addr;
                        if (p1_req && starve < STARVE_MAX) starve++;
                    end
                    ack_cyc = cyc + 3;
                end
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        p0_req      = 1'b0;
        p1_req      = 1'b0;
        p0_addr     = '0;
        p1_addr     = '0;
        for (int i = 0; i < 8192; i++) begin
            hi_mem[i] = 8'($urandom);
            lo_mem[i] = 8'($urandom);
        end
        hi_mem[0] = 8'h4E;
        lo_mem[0] = 8'h71;

        test_reset();
        test_single();
        test_both();
        test_starve();
        test_reset_mid();
        test_hold();
        test_data_hold();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
